serial_bit_feeder: RTL

- Upstream stimulus stage for the serial sequence-detector FSM. Accepts a parallel word through a valid/ready handshake and drives it MSB-first, one bit per clock, onto the detector's serial input `x`.
- Replaces hand-written bit toggling in benches and top levels with a deterministic, cycle-exact bit source.
- Flags each driven bit with `bit_valid` and pulses `done` after the word completes.

---
 rtl/feeder_pkg.sv | 30 +++
 rtl/feeder_shift_reg.sv | 36 +++
 rtl/serial_bit_feeder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/feeder_pkg.sv
// ============================================================================
// Module      : feeder_pkg
// Description : Shared state encoding, idle level and parity helper for the
//               serial bit feeder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package feeder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic IDLE_LEVEL = 1'b1;

   // Widest word the parity helper accepts; narrower words are zero-extended,
   // which leaves the XOR unchanged.
   localparam int PAR_MAX_W = 64;

   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
      return ^word;
   endfunction

endpackage

`default_nettype wire

// File: rtl/feeder_shift_reg.sv
// ============================================================================
// Module      : feeder_shift_reg
// Description : WIDTH-bit parallel-load, shift-left (zero fill) register with
//               an MSB tap.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module feeder_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_msb
);

   logic [WIDTH-1:0] r_sreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sreg <= '0;
      end else if (i_load) begin
         r_sreg <= i_data;
      end else if (i_shift) begin
         r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
      end
   end

   assign o_msb = r_sreg[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/serial_bit_feeder.sv
// ============================================================================
// Module      : serial_bit_feeder
// Description : Accepts a word over valid/ready and drives it MSB-first, one
//               bit per clock, with bit_valid/busy/done framing.
//               Define FEED_PARITY_EN to append an even-parity bit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module serial_bit_feeder
   import feeder_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_BIT = IDLE_LEVEL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             x_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             done
);

   localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_next;
   logic               w_load;
   logic               w_shift;
   logic               w_msb;

   feeder_shift_reg #(
      .WIDTH (WIDTH)
   ) u_sreg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (data_in),
      .o_msb   (w_msb)
   );

`ifdef FEED_PARITY_EN
   logic r_parity;

   // Parity is taken from the word as latched, not from the draining register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (w_load) begin
         r_parity <= even_parity(PAR_MAX_W'(data_in));
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_load     = 1'b0;
      w_shift    = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (load_valid) begin
               w_load     = 1'b1;
               w_cnt_next = '0;
               w_next     = ST_SHIFT;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (r_cnt == c_LAST) begin
               w_cnt_next = '0;
`ifdef FEED_PARITY_EN
               w_next     = ST_PAR;
`else
               w_next     = ST_DONE;
`endif
            end else begin
               w_cnt_next = r_cnt + c_CNT_W'(1);
            end
         end
`ifdef FEED_PARITY_EN
         ST_PAR: begin
            w_next = ST_DONE;
         end
`endif
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Every output is a decode of registered state; inputs never reach them.
   always_comb begin
      load_ready = 1'b0;
      bit_valid  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      x_out      = IDLE_BIT;
      case (r_state)
         ST_IDLE: begin
            load_ready = 1'b1;
         end
         ST_SHIFT: begin
            bit_valid = 1'b1;
            busy      = 1'b1;
            x_out     = w_msb;
         end
`ifdef FEED_PARITY_EN
         ST_PAR: begin
            bit_valid = 1'b1;
            busy      = 1'b1;
            x_out     = r_parity;
         end
`endif
         ST_DONE: begin
            load_ready = 1'b1;
            done       = 1'b1;
         end
         default: begin
            load_ready = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire
